// File: rtl/i2c_pkg.sv
// Shared types and constants for the I2C master receive path.
package i2c_pkg;

   localparam int I2C_MAX_BYTES = 8;
   localparam int I2C_BYTE_W    = 8;

   typedef enum logic [2:0] {
      IDLE,
      BITS,
      ACK_SETUP,
      ACK_HIGH,
      FINISH
   } rx_state_t;

   typedef logic [I2C_BYTE_W-1:0] byte_arr_t [0:I2C_MAX_BYTES-1];

endpackage

// File: rtl/i2c_sipo_byte.sv
// 8-bit serial-in parallel-out shift register, MSB arrives first.
module i2c_sipo_byte
   import i2c_pkg::*;
(
   input  logic                  clk,
   input  logic                  srst,
   input  logic                  clr,
   input  logic                  en,
   input  logic                  din,
   output logic [I2C_BYTE_W-1:0] q
);

   logic [I2C_BYTE_W-1:0] shift_q;
   logic [I2C_BYTE_W-1:0] shift_d;

   always_comb begin
      shift_d = shift_q;
      if (clr) begin
         shift_d = '0;
      end else if (en) begin
         shift_d = {shift_q[I2C_BYTE_W-2:0], din};
      end
   end

   always_ff @(posedge clk) begin
      if (srst) begin
         shift_q <= '0;
      end else begin
         shift_q <= shift_d;
      end
   end

   assign q = shift_q;

endmodule

// File: rtl/i2c_read_sequencer.sv
// Receive-side sequencer of the I2C master: samples up to MAX_BYTES bytes,
// stores them in a register array and drives ACK/NACK after each byte.
module i2c_read_sequencer
   import i2c_pkg::*;
#(
   parameter int MAX_BYTES = I2C_MAX_BYTES,
   parameter int IDX_W     = $clog2(MAX_BYTES)
)
(
   input  logic                  Clock,
   input  logic                  Reset,
   input  logic                  Start,
   input  logic [3:0]            Length,
   input  logic                  SdaIn,
   input  logic                  SclRise,
   input  logic                  SclFall,
   output logic                  SdaOe,
   output logic                  Busy,
   output logic                  Done,
   output logic [3:0]            Count,
   output logic [I2C_BYTE_W-1:0] Data [0:MAX_BYTES-1]
);

   localparam logic [3:0] MAX_LEN = 4'(MAX_BYTES);

   rx_state_t             state_q, state_d;
   logic [3:0]            len_q, len_d;
   logic [3:0]            count_q, count_d;
   logic [2:0]            bitcnt_q, bitcnt_d;
   logic                  sda_oe_q, sda_oe_d;
   logic                  done_q, done_d;

   logic                  shift_clr;
   logic                  shift_en;
   logic                  wr_en;
   logic                  fall_ok;
   logic [3:0]            len_clamped;
   logic [I2C_BYTE_W-1:0] shift_byte;
   logic [I2C_BYTE_W-1:0] rx_byte;

   i2c_sipo_byte u_sipo (
      .clk  (Clock),
      .srst (Reset),
      .clr  (shift_clr),
      .en   (shift_en),
      .din  (SdaIn),
      .q    (shift_byte)
   );

   // The byte is committed on the same strobe that delivers its last bit.
   assign rx_byte     = {shift_byte[I2C_BYTE_W-2:0], SdaIn};
   assign fall_ok     = SclFall & ~SclRise;
   assign len_clamped = (Length > MAX_LEN) ? MAX_LEN : Length;

   always_comb begin
      state_d   = state_q;
      len_d     = len_q;
      count_d   = count_q;
      bitcnt_d  = bitcnt_q;
      sda_oe_d  = sda_oe_q;
      shift_clr = 1'b0;
      shift_en  = 1'b0;
      wr_en     = 1'b0;
      case (state_q)
         IDLE: begin
            if (Start) begin
               len_d     = len_clamped;
               count_d   = '0;
               bitcnt_d  = '0;
               shift_clr = 1'b1;
               state_d   = (len_clamped == 4'd0) ? FINISH : BITS;
            end
         end
         BITS: begin
            if (SclRise) begin
               shift_en = 1'b1;
               bitcnt_d = bitcnt_q + 3'd1;
               if (bitcnt_q == 3'd7) begin
                  wr_en   = 1'b1;
                  count_d = count_q + 4'd1;
                  state_d = ACK_SETUP;
               end
            end
         end
         ACK_SETUP: begin
            if (fall_ok) begin
               sda_oe_d = (count_q < len_q);
               state_d  = ACK_HIGH;
            end
         end
         ACK_HIGH: begin
            if (fall_ok) begin
               sda_oe_d = 1'b0;
               bitcnt_d = '0;
               state_d  = (count_q == len_q) ? FINISH : BITS;
            end
         end
         FINISH: begin
            state_d = IDLE;
         end
         default: begin
            state_d = IDLE;
         end
      endcase
   end

   assign done_d = (state_q == FINISH);

   always_ff @(posedge Clock) begin
      if (Reset) begin
         state_q  <= IDLE;
         len_q    <= '0;
         count_q  <= '0;
         bitcnt_q <= '0;
         sda_oe_q <= 1'b0;
         done_q   <= 1'b0;
      end else begin
         state_q  <= state_d;
         len_q    <= len_d;
         count_q  <= count_d;
         bitcnt_q <= bitcnt_d;
         sda_oe_q <= sda_oe_d;
         done_q   <= done_d;
      end
   end

   for (genvar gi = 0; gi < MAX_BYTES; gi++) begin : g_entry
      logic [I2C_BYTE_W-1:0] entry_q, entry_d;

      always_comb begin
         entry_d = entry_q;
         if (wr_en && (count_q[IDX_W-1:0] == IDX_W'(gi))) begin
            entry_d = rx_byte;
         end
      end

      always_ff @(posedge Clock) begin
         if (Reset) begin
            entry_q <= '0;
         end else begin
            entry_q <= entry_d;
         end
      end

      assign Data[gi] = entry_q;
   end

   assign SdaOe = sda_oe_q;
   assign Busy  = (state_q != IDLE);
   assign Done  = done_q;
   assign Count = count_q;

endmodule

// File: tb/tb_i2c_read_sequencer.sv
// Directed bench for i2c_read_sequencer: a transaction table plus hand-written
// sequences for mid-transaction reset, ignored Start and coincident strobes.
module tb_i2c_read_sequencer;

   logic       Clock;
   logic       Reset;
   logic       Start;
   logic [3:0] Length;
   logic       SdaIn;
   logic       SclRise;
   logic       SclFall;
   logic       SdaOe;
   logic       Busy;
   logic       Done;
   logic [3:0] Count;
   logic [7:0] data_o [0:7];

   logic [7:0] exp_data [0:7];
   int         checks;
   int         failures;
   int         done_cnt;

   typedef struct {
      logic [3:0]  len;
      logic [63:0] bytes;
      int          exp_n;
      int          mode;
   } vec_t;

   vec_t vecs [6];

   i2c_read_sequencer dut (
      .Clock   (Clock),
      .Reset   (Reset),
      .Start   (Start),
      .Length  (Length),
      .SdaIn   (SdaIn),
      .SclRise (SclRise),
      .SclFall (SclFall),
      .SdaOe   (SdaOe),
      .Busy    (Busy),
      .Done    (Done),
      .Count   (Count),
      .Data    (data_o)
   );

   initial Clock = 1'b0;
   always #5 Clock = ~Clock;

   initial done_cnt = 0;
   always @(posedge Clock) begin
      if (Done) done_cnt <= done_cnt + 1;
   end

   task automatic tick;
      @(posedge Clock);
      #1;
   endtask

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
      checks++;
      if (act !== req) begin
         failures++;
         $display("FAIL %s actual=%0h required=%0h", name, act, req);
      end
   endtask

   task automatic check_data(input string tag);
      for (int i = 0; i < 8; i++) begin
         check($sformatf("%s_data%0d", tag, i), 32'(data_o[i]), 32'(exp_data[i]));
      end
   endtask

   task automatic rise(input logic b);
      SdaIn = b; SclRise = 1'b1;
      tick;
      SclRise = 1'b0;
      tick;
   endtask

   task automatic fall;
      SclFall = 1'b1;
      tick;
      SclFall = 1'b0;
      tick;
   endtask

   // mode 0: plain; 1: Start with Length=5 injected mid-byte;
   // 2: stray SclFall in BITS plus coincident strobes in BITS and ACK_SETUP.
   task automatic read_txn(input logic [3:0] len, input logic [63:0] bytes,
                           input int exp_n, input int mode, input string tag);
      int         d0;
      logic [7:0] b;
      logic       ack;
      d0 = done_cnt;
      Length = len; Start = 1'b1;
      tick;
      Start = 1'b0; Length = 4'hF;
      check({tag, "_busy_start"}, 32'(Busy), 32'd1);
      if (exp_n == 0) begin
         check({tag, "_done_early"}, 32'(Done), 32'd0);
         tick;
         check({tag, "_done"}, 32'(Done), 32'd1);
         check({tag, "_busy_end"}, 32'(Busy), 32'd0);
         check({tag, "_sdaoe"}, 32'(SdaOe), 32'd0);
         tick;
         check({tag, "_done_off"}, 32'(Done), 32'd0);
      end
      for (int i = 0; i < exp_n; i++) begin
         b = bytes[8*i +: 8];
         for (int k = 7; k >= 0; k--) begin
            if (mode == 1 && i == 0 && k == 4) begin
               Start = 1'b1; Length = 4'd5;
               tick;
               Start = 1'b0;
            end
            if (mode == 2 && k == 5) fall();
            if (mode == 2 && k == 3) begin
               SdaIn = b[k]; SclRise = 1'b1; SclFall = 1'b1;
               tick;
               SclRise = 1'b0; SclFall = 1'b0;
               tick;
            end else begin
               rise(b[k]);
            end
         end
         exp_data[i] = b;
         check($sformatf("%s_count%0d", tag, i), 32'(Count), 32'(i + 1));
         check($sformatf("%s_byte%0d", tag, i), 32'(data_o[i]), 32'(b));
         if (mode == 2) begin
            SclRise = 1'b1; SclFall = 1'b1;
            tick;
            SclRise = 1'b0; SclFall = 1'b0;
            tick;
            check($sformatf("%s_both_oe%0d", tag, i), 32'(SdaOe), 32'd0);
         end
         ack = (i < exp_n - 1);
         fall();
         check($sformatf("%s_ack%0d", tag, i), 32'(SdaOe), 32'(ack));
         rise(1'b1);
         check($sformatf("%s_ackhold%0d", tag, i), 32'(SdaOe), 32'(ack));
         if (i == exp_n - 1) begin
            SclFall = 1'b1;
            tick;
            SclFall = 1'b0;
            check({tag, "_done_early"}, 32'(Done), 32'd0);
            check({tag, "_busy_fin"}, 32'(Busy), 32'd1);
            tick;
            check({tag, "_done"}, 32'(Done), 32'd1);
            check({tag, "_busy_end"}, 32'(Busy), 32'd0);
            check({tag, "_sdaoe_end"}, 32'(SdaOe), 32'd0);
            tick;
            check({tag, "_done_off"}, 32'(Done), 32'd0);
         end else begin
            fall();
            check($sformatf("%s_release%0d", tag, i), 32'(SdaOe), 32'd0);
         end
      end
      check({tag, "_done_pulses"}, 32'(done_cnt - d0), 32'd1);
      check({tag, "_count"}, 32'(Count), 32'(exp_n));
      check_data(tag);
      $display("txn %s len=%0d count=%0d done_pulses=%0d", tag, len, Count, done_cnt - d0);
   endtask

   initial begin
      checks = 0; failures = 0;
      Reset = 1'b1; Start = 1'b0; Length = 4'd0;
      SdaIn = 1'b0; SclRise = 1'b0; SclFall = 1'b0;
      for (int i = 0; i < 8; i++) exp_data[i] = 8'h00;

      vecs[0] = '{len: 4'd1,  bytes: 64'h00000000000000A5, exp_n: 1, mode: 0};
      vecs[1] = '{len: 4'd3,  bytes: 64'h000000000000FF3C, exp_n: 3, mode: 0};
      vecs[2] = '{len: 4'd0,  bytes: 64'h0000000000000000, exp_n: 0, mode: 0};
      vecs[3] = '{len: 4'd12, bytes: 64'hF0E1D2C3B4A59687, exp_n: 8, mode: 0};
      vecs[4] = '{len: 4'd2,  bytes: 64'h000000000000BEEF, exp_n: 2, mode: 1};
      vecs[5] = '{len: 4'd2,  bytes: 64'h0000000000001234, exp_n: 2, mode: 2};

      tick; tick;
      Reset = 1'b0;
      tick;
      check("rst_busy", 32'(Busy), 32'd0);
      check("rst_done", 32'(Done), 32'd0);
      check("rst_sdaoe", 32'(SdaOe), 32'd0);
      check("rst_count", 32'(Count), 32'd0);
      check_data("rst");
      $display("txn reset busy=%0d count=%0d", Busy, Count);

      for (int v = 0; v < 6; v++) begin
         read_txn(vecs[v].len, vecs[v].bytes, vecs[v].exp_n, vecs[v].mode,
                  $sformatf("v%0d", v));
         // Strobes in IDLE must not disturb anything.
         rise(1'b1); fall(); rise(1'b0);
         check($sformatf("v%0d_idle_busy", v), 32'(Busy), 32'd0);
         check($sformatf("v%0d_idle_oe", v), 32'(SdaOe), 32'd0);
         check($sformatf("v%0d_idle_count", v), 32'(Count), 32'(vecs[v].exp_n));
      end

      // Reset in the middle of byte 1 of a two-byte read.
      Length = 4'd2; Start = 1'b1;
      tick;
      Start = 1'b0;
      for (int k = 7; k >= 0; k--) rise(k[0]);
      fall(); rise(1'b1); fall();
      rise(1'b1); rise(1'b0); rise(1'b1); rise(1'b1);
      check("mid_busy_pre", 32'(Busy), 32'd1);
      Reset = 1'b1;
      tick;
      Reset = 1'b0;
      for (int i = 0; i < 8; i++) exp_data[i] = 8'h00;
      check("mid_busy", 32'(Busy), 32'd0);
      check("mid_sdaoe", 32'(SdaOe), 32'd0);
      check("mid_count", 32'(Count), 32'd0);
      check("mid_done", 32'(Done), 32'd0);
      check_data("mid");
      $display("txn midreset busy=%0d count=%0d", Busy, Count);
      tick;
      read_txn(4'd1, 64'h00000000000000C3, 1, 0, "post");

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
